// File: rtl/cdb_arbiter_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_buffered
//  Description : Functional-unit to common-data-bus writeback arbiter. Each
//                source has a small result FIFO. Up to NUM_CDB heads are
//                granted per cycle in rotating round-robin order onto
//                registered CDB lanes.
//                Optional starvation guard: define CDB_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_buffered #(
    parameter int NUM_SRC   = 8,
    parameter int NUM_CDB   = 2,
    parameter int BUF_DEPTH = 2,
    parameter int DATA_W    = 32,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]      src_value,
    input  logic [NUM_SRC*PRF_IDX_W-1:0]   src_prf_idx,
    input  logic [NUM_SRC*ROB_IDX_W-1:0]   src_rob_idx,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic [NUM_CDB-1:0]             cdb_valid,
    output logic [NUM_CDB*DATA_W-1:0]      cdb_value,
    output logic [NUM_CDB*PRF_IDX_W-1:0]   cdb_prf_idx,
    output logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int c_ENT_W = ROB_IDX_W + PRF_IDX_W + DATA_W;

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Entry layout: {rob_idx, prf_idx, value}
    logic [c_ENT_W-1:0] w_src_ent  [NUM_SRC];
    logic [c_ENT_W-1:0] w_head_ent [NUM_SRC];
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [NUM_SRC-1:0] w_nonempty;
    logic               w_flush;

    logic [c_SRC_W-1:0] r_rr_ptr;
    logic [c_SRC_W-1:0] w_rr_next;
    logic               w_any_grant;
    logic [NUM_CDB-1:0] w_lane_vld;
    logic [c_SRC_W-1:0] w_lane_src [NUM_CDB];

    logic [NUM_CDB-1:0] r_cdb_valid;
    logic [c_ENT_W-1:0] r_cdb_ent [NUM_CDB];

    assign w_flush = reset | squash;

    // ------------------------------------------------------------------------
    // Per-source result FIFOs
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [c_ENT_W-1:0] r_mem [BUF_DEPTH];
        logic [c_PTR_W-1:0] r_head;
        logic [c_PTR_W-1:0] r_tail;
        logic [c_CNT_W-1:0] r_count;

        assign w_src_ent[gi]  = {src_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W],
                                 src_prf_idx[gi*PRF_IDX_W +: PRF_IDX_W],
                                 src_value[gi*DATA_W +: DATA_W]};
        // Ready looks only at the registered count: no credit for a same-cycle pop
        assign src_ready[gi]  = (r_count != c_FULL);
        assign w_push[gi]     = src_valid[gi] & src_ready[gi];
        assign w_nonempty[gi] = (r_count != '0);
        assign w_head_ent[gi] = r_mem[r_head];

        // Pointer and occupancy bookkeeping; flush empties the queue
        always_ff @(posedge clock) begin
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[gi]) r_tail <= r_tail + c_PTR_ONE;
                if (w_pop[gi])  r_head <= r_head + c_PTR_ONE;
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage write at the tail; pushes in a flush cycle are discarded
        always_ff @(posedge clock) begin
            if (w_push[gi] && !w_flush) r_mem[r_tail] <= w_src_ent[gi];
        end
    end

`ifdef CDB_ARB_STARVE_GUARD_EN
    logic [3:0] r_age [NUM_SRC];

    // Saturating wait-age per source: cycles spent non-empty without a grant
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_flush || w_pop[i]) begin
                r_age[i] <= '0;
            end else if (w_nonempty[i] && (r_age[i] != 4'hF)) begin
                r_age[i] <= r_age[i] + 4'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Grant selection: starved sources first (if enabled), then round-robin
    // scan from r_rr_ptr; grant k goes to lane k in selection order.
    // ------------------------------------------------------------------------
    always_comb begin
        int                 n;
        int                 idx_i;
        int                 last;
        logic [c_SRC_W-1:0] idx;
        logic [NUM_SRC-1:0] taken;

        n          = 0;
        idx_i      = 0;
        last       = 0;
        idx        = '0;
        taken      = '0;
        w_lane_vld = '0;
        for (int k = 0; k < NUM_CDB; k++) w_lane_src[k] = '0;

`ifdef CDB_ARB_STARVE_GUARD_EN
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_nonempty[i] && (r_age[i] == 4'hF) && (n < NUM_CDB)) begin
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == n) begin
                        w_lane_vld[k] = 1'b1;
                        w_lane_src[k] = c_SRC_W'(i);
                    end
                end
                taken[i] = 1'b1;
                last     = i;
                n        = n + 1;
            end
        end
`endif

        for (int off = 0; off < NUM_SRC; off++) begin
            idx_i = int'(r_rr_ptr) + off;
            if (idx_i >= NUM_SRC) idx_i = idx_i - NUM_SRC;
            idx = c_SRC_W'(idx_i);
            if (w_nonempty[idx] && !taken[idx] && (n < NUM_CDB)) begin
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == n) begin
                        w_lane_vld[k] = 1'b1;
                        w_lane_src[k] = idx;
                    end
                end
                taken[idx] = 1'b1;
                last       = idx_i;
                n          = n + 1;
            end
        end

        w_pop       = taken;
        w_any_grant = (n != 0);
        w_rr_next   = (last >= NUM_SRC - 1) ? '0 : c_SRC_W'(last + 1);
    end

    // Round-robin pointer: follows the last granted source, kept on squash
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (!squash && w_any_grant) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Registered CDB lanes; payload holds its last value when not valid
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cdb_valid <= '0;
            for (int k = 0; k < NUM_CDB; k++) r_cdb_ent[k] <= '0;
        end else if (squash) begin
            r_cdb_valid <= '0;
        end else begin
            r_cdb_valid <= w_lane_vld;
            for (int k = 0; k < NUM_CDB; k++) begin
                if (w_lane_vld[k]) r_cdb_ent[k] <= w_head_ent[w_lane_src[k]];
            end
        end
    end

    assign cdb_valid = r_cdb_valid;

    for (genvar gk = 0; gk < NUM_CDB; gk++) begin : g_lane
        assign cdb_value[gk*DATA_W +: DATA_W]         = r_cdb_ent[gk][DATA_W-1:0];
        assign cdb_prf_idx[gk*PRF_IDX_W +: PRF_IDX_W] = r_cdb_ent[gk][DATA_W +: PRF_IDX_W];
        assign cdb_rob_idx[gk*ROB_IDX_W +: ROB_IDX_W] = r_cdb_ent[gk][DATA_W+PRF_IDX_W +: ROB_IDX_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter_buffered
//  Description : Directed self-checking bench for cdb_arbiter_buffered.
//                Instance u_dut uses NUM_CDB=2, instance u_dut1 uses NUM_CDB=1
//                (single-lane round-robin / starvation scenario).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cdb_arbiter_buffered;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              squash;
    logic [NS-1:0]     src_valid;
    logic [NS*DW-1:0]  src_value;
    logic [NS*PW-1:0]  src_prf_idx;
    logic [NS*RW-1:0]  src_rob_idx;
    logic [NS-1:0]     src_ready;
    logic [1:0]        cdb_valid;
    logic [2*DW-1:0]   cdb_value;
    logic [2*PW-1:0]   cdb_prf_idx;
    logic [2*RW-1:0]   cdb_rob_idx;

    logic [NS-1:0]     b_ready;
    logic [0:0]        b_valid;
    logic [DW-1:0]     b_value;
    logic [PW-1:0]     b_prf_idx;
    logic [RW-1:0]     b_rob_idx;

    int checks = 0;
    int errors = 0;

    cdb_arbiter_buffered #(
        .NUM_SRC(NS), .NUM_CDB(2), .BUF_DEPTH(2),
        .DATA_W(DW), .PRF_IDX_W(PW), .ROB_IDX_W(RW)
    ) u_dut (
        .clock(clk), .reset(reset), .squash(squash),
        .src_valid(src_valid), .src_value(src_value),
        .src_prf_idx(src_prf_idx), .src_rob_idx(src_rob_idx),
        .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_value(cdb_value),
        .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx)
    );

    cdb_arbiter_buffered #(
        .NUM_SRC(NS), .NUM_CDB(1), .BUF_DEPTH(2),
        .DATA_W(DW), .PRF_IDX_W(PW), .ROB_IDX_W(RW)
    ) u_dut1 (
        .clock(clk), .reset(reset), .squash(squash),
        .src_valid(src_valid), .src_value(src_value),
        .src_prf_idx(src_prf_idx), .src_rob_idx(src_rob_idx),
        .src_ready(b_ready), .cdb_valid(b_valid), .cdb_value(b_value),
        .cdb_prf_idx(b_prf_idx), .cdb_rob_idx(b_rob_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] v,
                           input logic [PW-1:0] p, input logic [RW-1:0] r);
        src_value[i*DW +: DW]   = v;
        src_prf_idx[i*PW +: PW] = p;
        src_rob_idx[i*RW +: RW] = r;
    endtask

    task automatic set_all_default();
        for (int i = 0; i < NS; i++) set_src(i, 32'h100 + DW'(i), PW'(i), RW'(i));
    endtask

    initial begin
        int          exp_seq [NS];
        int          sent    [NS];
        logic [NS-1:0] acc;
        logic [DW-1:0] lv;
        int          s;
        int          total;
        logic        seen5;

        reset       = 1'b1;
        squash      = 1'b0;
        src_valid   = '0;
        src_value   = '0;
        src_prf_idx = '0;
        src_rob_idx = '0;

        // ---------------- T1: reset with sources offering results ----------
        set_all_default();
        src_valid = 8'hFF;
        tick();
        chk("t1_valid_rst0", 64'(cdb_valid), 64'h0);
        chk("t1_ready_rst0", 64'(src_ready), 64'hFF);
        tick();
        chk("t1_valid_rst1", 64'(cdb_valid), 64'h0);
        reset     = 1'b0;
        src_valid = '0;
        tick();
        chk("t1_ready_after", 64'(src_ready), 64'hFF);
        chk("t1_valid_after", 64'(cdb_valid), 64'h0);
        chk("t1_payload_zero", 64'(cdb_value), 64'h0);
        tick();
        chk("t1_no_result", 64'(cdb_valid), 64'h0);

        // ---------------- T2: single-result latency ------------------------
        set_src(3, 32'hDEAD_BEEF, 6'd12, 5'd7);
        src_valid = 8'h08;
        tick();
        src_valid = '0;
        chk("t2_valid_t1", 64'(cdb_valid), 64'h0);
        tick();
        chk("t2_valid_t2", 64'(cdb_valid), 64'h1);
        chk("t2_value", 64'(cdb_value[31:0]), 64'hDEAD_BEEF);
        chk("t2_prf", 64'(cdb_prf_idx[5:0]), 64'd12);
        chk("t2_rob", 64'(cdb_rob_idx[4:0]), 64'd7);
        tick();
        chk("t2_valid_t3", 64'(cdb_valid), 64'h0);
        chk("t2_hold", 64'(cdb_value[31:0]), 64'hDEAD_BEEF);

        // ---------------- T3: round-robin fairness, all busy ---------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_all_default();
        for (int c = 0; c < 6; c++) begin
            src_valid = src_ready;
            tick();
            if (c == 0) begin
                chk("t3_first", 64'(cdb_valid), 64'h0);
            end else begin
                chk("t3_valid", 64'(cdb_valid), 64'h3);
                chk("t3_lane0", 64'(cdb_value[31:0]),  64'h100 + 64'(2*((c-1)%4)));
                chk("t3_lane1", 64'(cdb_value[63:32]), 64'h101 + 64'(2*((c-1)%4)));
            end
        end
        src_valid = '0;

        // ---------------- T4: backpressure, 3 results per source -----------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total = 0;
        for (int i = 0; i < NS; i++) begin
            exp_seq[i] = 0;
            sent[i]    = 0;
        end
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < NS; i++) begin
                set_src(i, {16'h0, 8'(i), 8'(sent[i])}, PW'(i), RW'(sent[i]));
                src_valid[i] = (sent[i] < 3) && src_ready[i];
            end
            acc = src_valid & src_ready;
            tick();
            for (int i = 0; i < NS; i++) if (acc[i]) sent[i]++;
            if (c == 1) chk("t4_ready_full", 64'(src_ready), 64'h03);
            for (int k = 0; k < 2; k++) begin
                if (cdb_valid[k] === 1'b1) begin
                    lv = cdb_value[k*DW +: DW];
                    s  = int'(lv[15:8]);
                    total++;
                    if (s < NS) begin
                        chk("t4_order", 64'(lv[7:0]), 64'(exp_seq[s]));
                        exp_seq[s]++;
                    end else begin
                        chk("t4_src_range", 64'(s), 64'(NS - 1));
                    end
                end
            end
        end
        src_valid = '0;
        chk("t4_total", 64'(total), 64'd24);
        for (int i = 0; i < NS; i++) chk("t4_per_src", 64'(exp_seq[i]), 64'd3);

        // ---------------- T5: squash with a concurrent push ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_all_default();
        src_valid = src_ready;
        tick();
        chk("t5_fill0", 64'(cdb_valid), 64'h0);
        src_valid = src_ready;
        tick();
        chk("t5_fill1", 64'(cdb_valid), 64'h3);
        chk("t5_fill1_l0", 64'(cdb_value[31:0]), 64'h100);
        squash    = 1'b1;
        src_valid = 8'h01;
        set_src(0, 32'h0000_0BAD, 6'd1, 5'd1);
        tick();
        squash    = 1'b0;
        src_valid = '0;
        chk("t5_valid_next", 64'(cdb_valid), 64'h0);
        chk("t5_ready", 64'(src_ready), 64'hFF);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_empty", 64'(cdb_valid), 64'h0);
        end
        set_all_default();
        src_valid = 8'hFF;
        tick();
        src_valid = '0;
        tick();
        chk("t5_rr_valid", 64'(cdb_valid), 64'h3);
        chk("t5_rr_lane0", 64'(cdb_value[31:0]),  64'h102);
        chk("t5_rr_lane1", 64'(cdb_value[63:32]), 64'h103);
        tick();
        chk("t5_next_lane0", 64'(cdb_value[31:0]), 64'h104);

        // ---------------- T6: single lane, source 5 must be served ---------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_all_default();
        seen5 = 1'b0;
        for (int c = 0; c < 17; c++) begin
            src_valid = b_ready;
            tick();
            if (b_valid === 1'b1 && b_value === 32'h105) seen5 = 1'b1;
            if (c == 0) begin
                chk("t6_first", 64'(b_valid), 64'h0);
            end else begin
                chk("t6_valid", 64'(b_valid), 64'h1);
                chk("t6_order", 64'(b_value), 64'h100 + 64'((c-1)%8));
            end
        end
        src_valid = '0;
        chk("t6_src5_served", 64'(seen5), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
